stack_ctrl: RTL and testbench

Stack-pointer and stack-transfer sequencer for the 8085 core. Holds the 16-bit stack pointer and runs the two-byte memory sequences for PUSH (pre-decrement, write) and POP (read, post-increment) over the byte-wide memory bus. It applies the counting operation of the core's incrementer/decrementer across a 16-bit pointer. It handles wrap-around and bus wait states.

---
 rtl/stack_ctrl_if.sv | 33 +++
 rtl/stack_ctrl.sv | 151 +++++++++++++++
 tb/tb_stack_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Command and byte-wide memory bus bundle for stack_ctrl.
// The slave side is the sequencer; the master side is the core plus memory.
interface stack_ctrl_if #(
    parameter int ADDRSIZE = 16,
    parameter int DATASIZE = 8
) ();
    logic                    iPush;
    logic                    iPop;
    logic                    iLoad;
    logic [ADDRSIZE-1:0]     iSP;
    logic [2*DATASIZE-1:0]   iWord;
    logic [DATASIZE-1:0]     iBusData;
    logic                    iBusReady;
    logic [ADDRSIZE-1:0]     oAddr;
    logic                    oBusRd;
    logic                    oBusWr;
    logic [DATASIZE-1:0]     oBusData;
    logic [2*DATASIZE-1:0]   oWord;
    logic [ADDRSIZE-1:0]     oSP;
    logic                    oBusy;
    logic                    oDone;
    logic                    oWrap;

    modport slave (
        input  iPush, iPop, iLoad, iSP, iWord, iBusData, iBusReady,
        output oAddr, oBusRd, oBusWr, oBusData, oWord, oSP, oBusy, oDone, oWrap
    );

    modport master (
        output iPush, iPop, iLoad, iSP, iWord, iBusData, iBusReady,
        input  oAddr, oBusRd, oBusWr, oBusData, oWord, oSP, oBusy, oDone, oWrap
    );
endinterface

// File: rtl/stack_ctrl.sv
// 8085 stack pointer with two-byte PUSH (pre-decrement) / POP (post-increment)
// sequencing over a byte-wide bus that may insert wait states.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | accepting load / push / pop (priority in that order)
// S_PUSH_HI | writing high byte at SP-1
// S_PUSH_LO | writing low byte at SP-2
// S_POP_LO  | reading low byte at SP
// S_POP_HI  | reading high byte at SP+1
// S_DONE    | one-cycle completion pulse, SP already updated
module stack_ctrl #(
    parameter int                  ADDRSIZE = 16,
    parameter int                  DATASIZE = 8,
    parameter logic [ADDRSIZE-1:0] RESETSP  = 16'h0000
) (
    input  logic        iClock,
    input  logic        iReset,
    stack_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_HI = 3'd1,
        S_PUSH_LO = 3'd2,
        S_POP_LO  = 3'd3,
        S_POP_HI  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [ADDRSIZE-1:0] ONE      = ADDRSIZE'(1);
    localparam logic [ADDRSIZE-1:0] ADDR_MAX = '1;

    state_t                  state_q, state_d;
    logic [ADDRSIZE-1:0]     sp_q, sp_d;
    logic [ADDRSIZE-1:0]     addr_q, addr_d;
    logic [DATASIZE-1:0]     wdata_q, wdata_d;
    logic [DATASIZE-1:0]     lo_q, lo_d;
    logic [2*DATASIZE-1:0]   word_q, word_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    wrap_q, wrap_d;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            sp_q    <= RESETSP;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            word_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            word_q  <= word_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.iLoad) begin
                    if (bus.iPush)     state_d = S_PUSH_HI;
                    else if (bus.iPop) state_d = S_POP_LO;
                end
            end
            S_PUSH_HI: if (bus.iBusReady) state_d = S_PUSH_LO;
            S_PUSH_LO: if (bus.iBusReady) state_d = S_DONE;
            S_POP_LO:  if (bus.iBusReady) state_d = S_POP_HI;
            S_POP_HI:  if (bus.iBusReady) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Wrap flag accumulates every borrow/carry of the running operation.
    always_comb begin
        sp_d    = sp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        word_d  = word_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.iLoad) begin
                    sp_d = bus.iSP;
                end else if (bus.iPush) begin
                    addr_d  = sp_q - ONE;
                    wdata_d = bus.iWord[2*DATASIZE-1:DATASIZE];
                    lo_d    = bus.iWord[DATASIZE-1:0];
                    wr_d    = 1'b1;
                    wrap_d  = (sp_q == '0);
                end else if (bus.iPop) begin
                    addr_d = sp_q;
                    rd_d   = 1'b1;
                    wrap_d = 1'b0;
                end
            end
            S_PUSH_HI: begin
                if (bus.iBusReady) begin
                    addr_d  = addr_q - ONE;
                    wdata_d = lo_q;
                    if (addr_q == '0) wrap_d = 1'b1;
                end
            end
            S_PUSH_LO: begin
                if (bus.iBusReady) begin
                    sp_d = addr_q;
                    wr_d = 1'b0;
                end
            end
            S_POP_LO: begin
                if (bus.iBusReady) begin
                    word_d[DATASIZE-1:0] = bus.iBusData;
                    addr_d               = addr_q + ONE;
                    if (addr_q == ADDR_MAX) wrap_d = 1'b1;
                end
            end
            S_POP_HI: begin
                if (bus.iBusReady) begin
                    word_d[2*DATASIZE-1:DATASIZE] = bus.iBusData;
                    sp_d                          = addr_q + ONE;
                    rd_d                          = 1'b0;
                    if (addr_q == ADDR_MAX) wrap_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.oAddr    = addr_q;
    assign bus.oBusRd   = rd_q;
    assign bus.oBusWr   = wr_q;
    assign bus.oBusData = wdata_q;
    assign bus.oWord    = word_q;
    assign bus.oSP      = sp_q;
    assign bus.oBusy    = (state_q != S_IDLE);
    assign bus.oDone    = (state_q == S_DONE);
    assign bus.oWrap    = wrap_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: transaction-level stack model, byte memory responder
// and a per-cycle compare process, with directed and randomized traffic.
module tb_stack_ctrl;
    logic iClock;
    logic iReset;

    stack_ctrl_if #(.ADDRSIZE(16), .DATASIZE(8)) bus ();

    stack_ctrl #(.ADDRSIZE(16), .DATASIZE(8), .RESETSP(16'h0000)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    logic [7:0]  mem [65536];
    bit          written [65536];

    logic [15:0] m_sp, m_word;
    logic        m_wrap;

    logic        exp_busy, exp_done, exp_rd, exp_wr, exp_wrap;
    logic [15:0] exp_sp, exp_word, exp_addr;
    logic [7:0]  exp_data;
    bit          chk_wrap, chk_word, chk_addr, chk_data;

    int          lit_cnt;
    string       lit_name [4];
    int          lit_sel [4];
    logic [15:0] lit_arg [4];
    logic [15:0] lit_exp [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        return written[a] ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5C);
    endfunction

    always @(posedge iClock) begin
        if (!iReset && bus.oBusWr && bus.iBusReady) begin
            mem[bus.oAddr]     <= bus.oBusData;
            written[bus.oAddr] <= 1'b1;
        end
    end

    function automatic void cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endfunction

    always @(negedge iClock) begin
        logic [15:0] act;
        cmp("busy",   {15'd0, bus.oBusy},  {15'd0, exp_busy});
        cmp("done",   {15'd0, bus.oDone},  {15'd0, exp_done});
        cmp("bus_rd", {15'd0, bus.oBusRd}, {15'd0, exp_rd});
        cmp("bus_wr", {15'd0, bus.oBusWr}, {15'd0, exp_wr});
        cmp("sp",     bus.oSP, exp_sp);
        if (chk_wrap) cmp("wrap", {15'd0, bus.oWrap}, {15'd0, exp_wrap});
        if (chk_word) cmp("word", bus.oWord, exp_word);
        if (chk_addr) cmp("addr", bus.oAddr, exp_addr);
        if (chk_data) cmp("bus_data", {8'd0, bus.oBusData}, {8'd0, exp_data});
        for (int i = 0; i < lit_cnt; i++) begin
            case (lit_sel[i])
                0:       act = bus.oSP;
                1:       act = bus.oWord;
                2:       act = {15'd0, bus.oWrap};
                default: act = {8'd0, rd_mem(lit_arg[i])};
            endcase
            cmp(lit_name[i], act, lit_exp[i]);
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
        lit_cnt = 0;
    endtask

    task automatic set_idle();
        exp_busy = 1'b0; exp_done = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_sp = m_sp; exp_wrap = m_wrap; exp_word = m_word;
        chk_wrap = 1'b1; chk_word = 1'b1; chk_addr = 1'b0; chk_data = 1'b0;
    endtask

    task automatic quiet_inputs();
        bus.iPush = 1'b0; bus.iPop = 1'b0; bus.iLoad = 1'b0;
        bus.iSP = 16'($urandom); bus.iWord = 16'($urandom);
        bus.iBusData = 8'($urandom); bus.iBusReady = 1'($urandom);
    endtask

    // Commands while busy must be ignored; pop is held high on purpose.
    task automatic junk_inputs();
        bus.iPush = 1'($urandom); bus.iPop = 1'b1; bus.iLoad = 1'($urandom);
        bus.iSP = 16'($urandom); bus.iWord = 16'($urandom);
        bus.iBusData = 8'($urandom); bus.iBusReady = 1'($urandom);
    endtask

    task automatic add_lit(input string nm, input int sel, input logic [15:0] arg, input logic [15:0] req);
        lit_name[lit_cnt] = nm;
        lit_sel[lit_cnt]  = sel;
        lit_arg[lit_cnt]  = arg;
        lit_exp[lit_cnt]  = req;
        lit_cnt++;
    endtask

    task automatic do_idle();
        quiet_inputs();
        tick();
        set_idle();
    endtask

    task automatic do_load(input logic [15:0] sp, input logic with_push, input logic with_pop);
        quiet_inputs();
        bus.iLoad = 1'b1; bus.iSP = sp; bus.iPush = with_push; bus.iPop = with_pop;
        tick();
        m_sp = sp;
        set_idle();
    endtask

    // One PUSH or POP as a list of two byte accesses; w0/w1 are wait cycles.
    task automatic do_op(input bit is_pop, input logic [15:0] w, input int w0, input int w1, input bit both);
        logic [15:0] a [2];
        logic [7:0]  d [2];
        logic [15:0] new_sp, new_word;
        logic        new_wrap;
        int          n;
        if (!is_pop) begin
            a[0] = m_sp - 16'd1; a[1] = m_sp - 16'd2;
            d[0] = w[15:8];      d[1] = w[7:0];
            new_sp = m_sp - 16'd2; new_wrap = (m_sp < 16'd2); new_word = m_word;
        end else begin
            a[0] = m_sp; a[1] = m_sp + 16'd1;
            d[0] = 8'h00; d[1] = 8'h00;
            new_sp = m_sp + 16'd2; new_wrap = (m_sp > 16'hFFFD);
            new_word = {rd_mem(a[1]), rd_mem(a[0])};
        end
        quiet_inputs();
        bus.iPush = !is_pop; bus.iPop = is_pop | both; bus.iWord = w;
        tick();
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? w0 : w1;
            for (int k = 0; k <= n; k++) begin
                exp_busy = 1'b1; exp_done = 1'b0; exp_rd = is_pop; exp_wr = !is_pop;
                exp_sp = m_sp; exp_word = m_word;
                chk_wrap = 1'b0; chk_word = !is_pop;
                chk_addr = 1'b1; exp_addr = a[i];
                chk_data = !is_pop; exp_data = d[i];
                junk_inputs();
                bus.iBusReady = (k == n);
                if (k == n) bus.iBusData = rd_mem(a[i]);
                tick();
            end
        end
        m_sp = new_sp; m_wrap = new_wrap; m_word = new_word;
        set_idle();
        exp_busy = 1'b1; exp_done = 1'b1;
        junk_inputs();
        tick();
        set_idle();
        quiet_inputs();
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    int          r;
    logic [15:0] s;

    initial begin
        lit_cnt = 0;
        iReset = 1'b1;
        quiet_inputs();
        m_sp = 16'h0000; m_word = 16'h0000; m_wrap = 1'b0;
        set_idle();
        chk_addr = 1'b1; chk_data = 1'b1; exp_addr = 16'h0000; exp_data = 8'h00;
        add_lit("reset_sp", 0, 16'h0000, 16'h0000);
        tick();
        iReset = 1'b0;
        set_idle();
        do_idle();

        do_load(16'h2000, 1'b1, 1'b1);
        add_lit("load_sp", 0, 16'h0000, 16'h2000);

        do_op(1'b0, 16'hA55A, 0, 0, 1'b0);
        add_lit("push_sp",   0, 16'h0000, 16'h1FFE);
        add_lit("mem_1fff",  3, 16'h1FFF, 16'h00A5);
        add_lit("mem_1ffe",  3, 16'h1FFE, 16'h005A);
        add_lit("push_wrap", 2, 16'h0000, 16'h0000);

        do_op(1'b1, 16'h0000, 0, 0, 1'b0);
        add_lit("pop_word", 1, 16'h0000, 16'hA55A);
        add_lit("pop_sp",   0, 16'h0000, 16'h2000);

        do_op(1'b0, 16'h1357, 0, 1, 1'b1);
        add_lit("both_sp", 0, 16'h0000, 16'h1FFE);
        do_op(1'b1, 16'h0000, 1, 0, 1'b0);
        add_lit("both_word", 1, 16'h0000, 16'h1357);

        do_load(16'h0001, 1'b0, 1'b0);
        do_op(1'b0, 16'h1234, 0, 0, 1'b0);
        add_lit("wrap_push_sp",   0, 16'h0000, 16'hFFFF);
        add_lit("wrap_push_flag", 2, 16'h0000, 16'h0001);
        add_lit("mem_0000",       3, 16'h0000, 16'h0012);
        add_lit("mem_ffff",       3, 16'hFFFF, 16'h0034);
        do_op(1'b1, 16'h0000, 0, 0, 1'b0);
        add_lit("wrap_pop_word", 1, 16'h0000, 16'h1234);
        add_lit("wrap_pop_sp",   0, 16'h0000, 16'h0001);
        add_lit("wrap_pop_flag", 2, 16'h0000, 16'h0001);

        do_load(16'h2000, 1'b0, 1'b0);
        do_op(1'b0, 16'hC33C, 3, 0, 1'b0);
        add_lit("wait_sp",   0, 16'h0000, 16'h1FFE);
        add_lit("wait_wrap", 2, 16'h0000, 16'h0000);
        add_lit("mem_wait",  3, 16'h1FFF, 16'h00C3);

        // Reset while the low byte of a PUSH is waiting on the bus.
        do_load(16'h3000, 1'b0, 1'b0);
        quiet_inputs();
        bus.iPush = 1'b1; bus.iWord = 16'hBEEF;
        tick();
        quiet_inputs();
        exp_busy = 1'b1; exp_wr = 1'b1;
        chk_addr = 1'b1; exp_addr = 16'h2FFF; chk_data = 1'b1; exp_data = 8'hBE;
        bus.iBusReady = 1'b1;
        tick();
        bus.iBusReady = 1'b0;
        #2;
        iReset = 1'b1;
        m_sp = 16'h0000; m_word = 16'h0000; m_wrap = 1'b0;
        set_idle();
        chk_addr = 1'b1; exp_addr = 16'h0000; chk_data = 1'b1; exp_data = 8'h00;
        add_lit("rst_mid_sp", 0, 16'h0000, 16'h0000);
        tick();
        iReset = 1'b0;
        set_idle();
        chk_addr = 1'b1; chk_data = 1'b1;
        do_idle();

        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                case ($urandom_range(0, 6))
                    0:       s = 16'h0000;
                    1:       s = 16'h0001;
                    2:       s = 16'h0002;
                    3:       s = 16'hFFFD;
                    4:       s = 16'hFFFE;
                    5:       s = 16'hFFFF;
                    default: s = 16'($urandom);
                endcase
                do_load(s, 1'($urandom), 1'($urandom));
            end else if (r < 5) begin
                do_op(1'b0, 16'($urandom), rand_wait(), rand_wait(), 1'($urandom));
            end else if (r < 8) begin
                do_op(1'b1, 16'($urandom), rand_wait(), rand_wait(), 1'b0);
            end else begin
                do_idle();
            end
        end

        @(negedge iClock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
